receive: RTL and testbench
==========================

Name: receive

Overview:
UART receiver that pairs with the transmit block on the same serial link and bus interface. Samples the asynchronous rxd line using the 16x baud enable from the BRG, and deframes 1 start bit, 8 data bits (LSB first) and 1 stop bit. Holds the received byte in rx_buf and raises rda until the processor reads address 2'b00. Flags framing and overrun errors.

Parameters:
None. The frame format (8N1) and 16x oversampling are fixed.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
brg_rx_en  input  1  one-clk pulse at 16x baud rate, from the BRG
rxd  input  1  serial data in, asynchronous to clk, idles high
iocs  input  1  chip select from the processor bus
iorw  input  1  1 = read, 0 = write
ioaddr  input  2  register address; 2'b00 = data register
rx_buf  output  8  last correctly framed byte
rda  output  1  receive data available
ferr  output  1  framing error on the last frame
ovr  output  1  overrun: byte completed while rda was already 1

Behaviour:
- Reset values: rx_buf=8'h00, rda=0, ferr=0, ovr=0, state=IDLE, both sync flops=1, counters=0.
- Synchronizer: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only. This adds 2 clk of input latency.
- Counters:
  - samp_cnt: 4-bit, increments on brg_rx_en, wraps 15->0, zeroed on each state entry.
  - bit_cnt: 4-bit count of received data bits.
  - shift_reg: 8 bits; a sampled bit enters at bit 7 and the register shifts right, so the LSB arrives first.
- State machine:
  - IDLE: rxd_s==0 -> START, samp_cnt=0.
  - START: on the brg_rx_en tick where samp_cnt==7 (mid start bit):
    - rxd_s==0 -> DATA, samp_cnt=0, bit_cnt=0.
    - rxd_s==1 -> IDLE (glitch rejected, no flags change).
  - DATA: on the brg_rx_en tick where samp_cnt==15 (mid bit), shift rxd_s in and increment bit_cnt. After the 8th bit -> STOP, samp_cnt=0.
  - STOP: on the brg_rx_en tick where samp_cnt==15, sample the stop bit:
    - rxd_s==1: rx_buf<=shift_reg, rda<=1, ferr<=0, ovr<=rda_effective; -> IDLE.
    - rxd_s==0: rx_buf unchanged, rda unchanged, ferr<=1; -> BREAK.
  - BREAK: wait for rxd_s==1, then -> IDLE. This prevents a held-low line from retriggering frames.
- Latency: rda rises on the clk edge of the tick that samples the stop bit. For a line-to-rda figure, add the 2-clk sync delay to the 9.5 bit times after the start edge.
- Processor read: a cycle with iocs && iorw && ioaddr==2'b00 clears rda, ovr and ferr on the next edge.
  - Reads of other addresses have no effect.
  - Writes have no effect.
  - rx_buf is driven continuously; the bus mux is external.
- Simultaneous read and byte completion in the same cycle:
  - Completion wins: rda=1 and rx_buf holds the new byte.
  - ovr=0, because rda_effective = rda && !read.
- Overrun: a new good byte with rda=1 and no read overwrites rx_buf, keeps rda=1 and sets ovr=1.
- brg_rx_en low: state and samp_cnt hold. Only read-clear logic acts.
- Reset mid-frame: immediate return to reset values. The partial byte is discarded.

Test Plan:
- Send 0xA5 in 8N1 with brg_rx_en every 4 clk (64 clk/bit) -> rda=1 and rx_buf=8'hA5 after the stop-bit sample. ferr=0, ovr=0.
- With rda=1 from the previous case, read (iocs=1, iorw=1, ioaddr=00) -> rda=0 next edge, rx_buf still 8'hA5.
- Pull rxd low for 12 clk (3 ticks) then high -> returns to IDLE from START. rda, ferr and rx_buf are unchanged.
- Send 0x3C with the stop bit held 0, then hold rxd low 2 bit times -> ferr=1, rda=0, rx_buf unchanged. No new frame starts until rxd returns high.
- Send 0x11 then 0x22 with no read between -> rx_buf=8'h22, rda=1, ovr=1. Then send 0x33 with the read asserted exactly on the completion cycle -> rx_buf=8'h33, rda=1, ovr=0.
- Assert rst_n=0 mid-DATA of 0xFF, then release and send 0x5A -> outputs are at reset values during reset, then rx_buf=8'h5A with rda=1.

Source files
------------

// File: rtl/receive_if.sv
// Processor-side register bus of the UART receiver.
//   iocs   : chip select from the processor bus
//   iorw   : 1 = read, 0 = write
//   ioaddr : register address, 2'b00 = data register
//   rx_buf : last correctly framed byte (driven continuously)
//   rda    : receive data available
//   ferr   : framing error on the last frame
//   ovr    : overrun, byte completed while rda was already set
// master = processor side, slave = receiver side.
interface receive_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_buf;
    logic       rda;
    logic       ferr;
    logic       ovr;

    modport master (
        output iocs, iorw, ioaddr,
        input  rx_buf, rda, ferr, ovr
    );

    modport slave (
        input  iocs, iorw, ioaddr,
        output rx_buf, rda, ferr, ovr
    );
endinterface

// File: rtl/receive.sv
// UART receiver, 8N1 with 16x oversampling.
// Synchronises rxd, deframes start + 8 data bits (LSB first) + stop,
// holds the byte in rx_buf with rda set until the data register is read,
// and flags framing and overrun errors.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   brg_rx_en : one-clk pulse at 16x the baud rate
//   rxd       : asynchronous serial input, idles high
//   bus       : processor register bus (slave side), see receive_if
module receive (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      brg_rx_en,
    input  logic      rxd,
    receive_if.slave  bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t              state;
    logic                rxd_meta;
    logic                rxd_s;
    logic [CNT_W-1:0]    samp_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   rx_buf_q;
    logic                rda_q;
    logic                ferr_q;
    logic                ovr_q;
    logic                rd_c;

    // Data-register read strobe
    assign rd_c = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);

    assign bus.rx_buf = rx_buf_q;
    assign bus.rda    = rda_q;
    assign bus.ferr   = ferr_q;
    assign bus.ovr    = ovr_q;

    // Two-flop synchroniser; idle-high reset value avoids a false start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Deframing state machine and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_buf_q  <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            // Read-clear first; a frame event later in this block overrides it
            if (rd_c) begin
                rda_q  <= 1'b0;
                ferr_q <= 1'b0;
                ovr_q  <= 1'b0;
            end

            if (brg_rx_en) begin
                case (state)
                    IDLE: begin
                        samp_cnt <= '0;
                        if (!rxd_s) begin
                            state <= START;
                        end
                    end

                    // Re-check the line half a bit in to reject glitches
                    START: begin
                        if (samp_cnt == CNT_W'(7)) begin
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rxd_s ? IDLE : DATA;
                        end else begin
                            samp_cnt <= samp_cnt + CNT_W'(1);
                        end
                    end

                    DATA: begin
                        samp_cnt <= samp_cnt + CNT_W'(1);
                        if (samp_cnt == CNT_W'(15)) begin
                            shift_reg <= {rxd_s, shift_reg[DATA_W-1:1]};
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                samp_cnt <= '0;
                                state    <= STOP;
                            end
                        end
                    end

                    STOP: begin
                        samp_cnt <= samp_cnt + CNT_W'(1);
                        if (samp_cnt == CNT_W'(15)) begin
                            samp_cnt <= '0;
                            if (rxd_s) begin
                                rx_buf_q <= shift_reg;
                                rda_q    <= 1'b1;
                                ferr_q   <= 1'b0;
                                // A read landing on this cycle consumed the old byte
                                ovr_q    <= rda_q && !rd_c;
                                state    <= IDLE;
                            end else begin
                                ferr_q   <= 1'b1;
                                state    <= BREAK;
                            end
                        end
                    end

                    // Hold off until the line returns high so a long low is not reframed
                    BREAK: begin
                        samp_cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        samp_cnt <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_receive.sv
// Self-checking bench for the UART receiver.
// A frame-level model predicts, from the time each frame's start edge is
// driven, the clock edge on which the stop bit is sampled, and applies the
// register rules (read-clear, completion, overrun, framing error) there.
// The DUT status outputs are compared to the model every cycle, and a set
// of hand-computed literal values pins the model.
module tb_receive;

    logic clk = 1'b0;
    logic rst_n;
    logic brg_rx_en;
    logic rxd;

    receive_if bus ();

    receive dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .brg_rx_en (brg_rx_en),
        .rxd       (rxd),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far; edge n is the n-th rising edge
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         done;
        bit         good;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         ev_idx   = 0;
    int         bus_edge = -1;
    logic       bus_iorw_req = 1'b0;
    logic [1:0] bus_addr_req = 2'b00;

    logic [7:0] exp_buf  = 8'h00;
    logic       exp_rda  = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Stimulus for brg_rx_en (tick on every edge n with n % 4 == 0) and the bus
    initial begin
        brg_rx_en  = 1'b0;
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            brg_rx_en = (edge_cnt % 4 == 3);
            if (edge_cnt + 1 == bus_edge) begin
                bus.iocs   = 1'b1;
                bus.iorw   = bus_iorw_req;
                bus.ioaddr = bus_addr_req;
            end else begin
                bus.iocs   = 1'b0;
                bus.iorw   = 1'b0;
                bus.ioaddr = 2'b00;
            end
        end
    end

    // Register-level model driven by predicted frame completion edges
    always @(posedge clk or negedge rst_n) begin
        int  cur;
        bit  rd;
        bit  prev_rda;
        if (!rst_n) begin
            exp_buf  = 8'h00;
            exp_rda  = 1'b0;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            ev_idx   = evq.size();
        end else begin
            cur      = edge_cnt + 1;
            rd       = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);
            prev_rda = exp_rda;
            if (rd) begin
                exp_rda  = 1'b0;
                exp_ferr = 1'b0;
                exp_ovr  = 1'b0;
            end
            if (ev_idx < evq.size() && evq[ev_idx].done == cur) begin
                if (evq[ev_idx].good) begin
                    exp_buf  = evq[ev_idx].data;
                    exp_rda  = 1'b1;
                    exp_ferr = 1'b0;
                    exp_ovr  = prev_rda && !rd;
                end else begin
                    exp_ferr = 1'b1;
                end
                ev_idx = ev_idx + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // One bus cycle on the next-but-one edge
    task automatic bus_op(input logic iorw, input logic [1:0] addr);
        bus_iorw_req = iorw;
        bus_addr_req = addr;
        bus_edge     = edge_cnt + 2;
        repeat (3) step();
    endtask

    // Send one 8N1 frame at 64 clk per bit. The start edge is first seen by
    // the receiver on the first tick at least 3 edges later; the stop bit is
    // sampled 9.5 bit times (152 ticks = 608 edges) after that tick.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit,
                              input int extra_low, input bit rd_done);
        int         k0;
        int         det;
        ev_t        e;
        logic [9:0] bits;
        k0  = edge_cnt;
        det = k0 + 3;
        while (det % 4 != 0) det = det + 1;
        e.done = det + 608;
        e.good = stop_bit;
        e.data = d;
        evq.push_back(e);
        if (rd_done) begin
            bus_iorw_req = 1'b1;
            bus_addr_req = 2'b00;
            bus_edge     = e.done;
        end
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (64) step();
        end
        if (extra_low > 0) repeat (extra_low) step();
        rxd = 1'b1;
        repeat (40) step();
    endtask

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;

        // Per-cycle comparison against the model
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    n_chk = n_chk + 1;
                    if (bus.rx_buf !== exp_buf || bus.rda !== exp_rda ||
                        bus.ferr !== exp_ferr || bus.ovr !== exp_ovr) begin
                        n_err = n_err + 1;
                        $display("FAIL model edge=%0d: got buf=%h rda=%b ferr=%b ovr=%b, expected buf=%h rda=%b ferr=%b ovr=%b",
                                 edge_cnt, bus.rx_buf, bus.rda, bus.ferr, bus.ovr,
                                 exp_buf, exp_rda, exp_ferr, exp_ovr);
                    end
                end
            end
        join_none

        repeat (5) step();
        chk_en = 1'b1;
        check8("reset rx_buf", bus.rx_buf, 8'h00);
        check1("reset rda", bus.rda, 1'b0);
        check1("reset ferr", bus.ferr, 1'b0);
        check1("reset ovr", bus.ovr, 1'b0);
        rst_n = 1'b1;
        repeat (20) step();

        // Clean frame
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        check8("a5 rx_buf", bus.rx_buf, 8'hA5);
        check1("a5 rda", bus.rda, 1'b1);
        check1("a5 ferr", bus.ferr, 1'b0);
        check1("a5 ovr", bus.ovr, 1'b0);

        // Write and non-data-register read leave rda alone
        bus_op(1'b0, 2'b00);
        bus_op(1'b1, 2'b01);
        check1("other access rda", bus.rda, 1'b1);

        // Data-register read clears rda
        bus_op(1'b1, 2'b00);
        check1("read rda", bus.rda, 1'b0);
        check8("read rx_buf", bus.rx_buf, 8'hA5);

        // Short low pulse is rejected as a glitch
        rxd = 1'b0;
        repeat (12) step();
        rxd = 1'b1;
        repeat (60) step();
        check1("glitch rda", bus.rda, 1'b0);
        check1("glitch ferr", bus.ferr, 1'b0);
        check8("glitch rx_buf", bus.rx_buf, 8'hA5);

        // Bad stop bit, then line held low two more bit times
        send_frame(8'h3C, 1'b0, 128, 1'b0);
        check1("ferr ferr", bus.ferr, 1'b1);
        check1("ferr rda", bus.rda, 1'b0);
        check8("ferr rx_buf", bus.rx_buf, 8'hA5);

        // Overrun
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        check8("ovr rx_buf", bus.rx_buf, 8'h22);
        check1("ovr rda", bus.rda, 1'b1);
        check1("ovr ovr", bus.ovr, 1'b1);
        check1("ovr ferr", bus.ferr, 1'b0);

        // Read on the completion cycle: completion wins, no overrun
        send_frame(8'h33, 1'b1, 0, 1'b1);
        check8("coincide rx_buf", bus.rx_buf, 8'h33);
        check1("coincide rda", bus.rda, 1'b1);
        check1("coincide ovr", bus.ovr, 1'b0);

        // Reset in the middle of a frame
        fork
            send_frame(8'hFF, 1'b1, 0, 1'b0);
            begin
                repeat (200) step();
                rst_n = 1'b0;
                repeat (3) step();
                check8("midreset rx_buf", bus.rx_buf, 8'h00);
                check1("midreset rda", bus.rda, 1'b0);
                check1("midreset ovr", bus.ovr, 1'b0);
                repeat (2) step();
                rst_n = 1'b1;
            end
        join
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        check8("post reset rx_buf", bus.rx_buf, 8'h5A);
        check1("post reset rda", bus.rda, 1'b1);
        check1("post reset ovr", bus.ovr, 1'b0);

        repeat (10) step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
